// File: rtl/gb_psum_rd_arb_if.sv
// Bank-side read channels and PE-side psum bus of the PSUM global buffer read arbiter.
// Handshake: a beat moves on a rising clk edge where val and rdy are both high; val never waits on rdy.
interface gb_psum_rd_arb_if #(
  parameter int NUM_CH = 48,
  parameter int DW     = 512,
  parameter int CW     = 6
);
  logic [NUM_CH-1:0]    src_val;
  logic [NUM_CH-1:0]    src_rdy;
  logic [NUM_CH*DW-1:0] src_data;
  logic                 dst_val;
  logic                 dst_rdy;
  logic [DW-1:0]        dst_data;
  logic [CW-1:0]        dst_ch;
  logic                 dst_last;

  modport master (
    input  src_val, src_data, dst_rdy,
    output src_rdy, dst_val, dst_data, dst_ch, dst_last
  );

  modport slave (
    output src_val, src_data, dst_rdy,
    input  src_rdy, dst_val, dst_data, dst_ch, dst_last
  );
endinterface

// File: rtl/gb_psum_rd_arb.sv
// Read-psum arbiter: NUM_CH bank read channels onto one PE psum bus, round-robin or fixed
// priority, multi-beat burst grants, single-entry registered back-pressurable output.
module gb_psum_rd_arb #(
  parameter int NUM_CH = 48,
  parameter int DW     = 512,
  parameter int CW     = 6,
  parameter int BW     = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_mode,
  input  logic [BW-1:0] cfg_burst,
  gb_psum_rd_arb_if.master bus,
  output logic          busy,
  output logic [CW-1:0] dbg_ptr
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] ptr_q, grant_q, winner;
  logic [BW-1:0] len_q, beat_cnt_q;
  logic          mode_q;
  logic          win_found;
  int            rr_idx;

  logic          grant_val;
  logic [DW-1:0] grant_data;
  logic          out_free, beat, last_beat, release_g;

  logic          dst_val_q, dst_last_q;
  logic [DW-1:0] dst_data_q;
  logic [CW-1:0] dst_ch_q;

  // Winner search; the RR scan wraps at NUM_CH so unused indices are never reached.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    rr_idx    = 0;
    if (cfg_mode) begin
      for (int c = NUM_CH - 1; c >= 0; c--) begin
        if (bus.src_val[c]) begin
          winner    = CW'(c);
          win_found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        rr_idx = int'(ptr_q) + i;
        if (rr_idx >= NUM_CH) rr_idx = rr_idx - NUM_CH;
        if (!win_found && bus.src_val[rr_idx]) begin
          winner    = CW'(rr_idx);
          win_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_val  = 1'b0;
    grant_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant_q == CW'(c)) begin
        grant_val  = bus.src_val[c];
        grant_data = bus.src_data[c*DW +: DW];
      end
    end
  end

  assign out_free  = ~dst_val_q | bus.dst_rdy;
  assign beat      = (state_q == GRANT) & grant_val & out_free;
  assign last_beat = beat & (beat_cnt_q == len_q - BW'(1));
  assign release_g = (state_q == GRANT) & ~grant_val;

  always_comb begin
    bus.src_rdy = '0;
    if (state_q == GRANT && out_free) begin
      for (int c = 0; c < NUM_CH; c++) begin
        bus.src_rdy[c] = (grant_q == CW'(c));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = GRANT;
      GRANT:   if (last_beat || release_g) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      mode_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      // Mode and burst length are frozen for the whole grant.
      if (state_q == IDLE && win_found) begin
        grant_q    <= winner;
        len_q      <= (cfg_burst == '0) ? BW'(1) : cfg_burst;
        mode_q     <= cfg_mode;
        beat_cnt_q <= '0;
      end
      if (beat) beat_cnt_q <= beat_cnt_q + BW'(1);
      if ((last_beat || release_g) && !mode_q) begin
        ptr_q <= (grant_q == CW'(NUM_CH - 1)) ? '0 : grant_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dst_val_q  <= 1'b0;
      dst_data_q <= '0;
      dst_ch_q   <= '0;
      dst_last_q <= 1'b0;
    end else if (beat) begin
      dst_val_q  <= 1'b1;
      dst_data_q <= grant_data;
      dst_ch_q   <= grant_q;
      dst_last_q <= (beat_cnt_q == len_q - BW'(1));
    end else if (bus.dst_rdy) begin
      dst_val_q <= 1'b0;
    end
  end

  assign bus.dst_val  = dst_val_q;
  assign bus.dst_data = dst_data_q;
  assign bus.dst_ch   = dst_ch_q;
  assign bus.dst_last = dst_last_q;

  assign busy    = (state_q != IDLE) | dst_val_q;
  assign dbg_ptr = ptr_q;

endmodule

// File: tb/tb_gb_psum_rd_arb.sv
// Directed bench for gb_psum_rd_arb: expected beats are queued by the stimulus and
// checked by an independent output monitor.
module tb_gb_psum_rd_arb;
  localparam int NUM_CH = 48;
  localparam int DW     = 512;
  localparam int CW     = 6;
  localparam int BW     = 4;
  localparam int EW     = CW + 9;

  // clock / reset
  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_mode;
  logic [BW-1:0] cfg_burst;
  logic          busy;
  logic [CW-1:0] dbg_ptr;

  always #5 clk = ~clk;

  gb_psum_rd_arb_if #(.NUM_CH(NUM_CH), .DW(DW), .CW(CW)) bus ();

  gb_psum_rd_arb #(.NUM_CH(NUM_CH), .DW(DW), .CW(CW), .BW(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_mode  (cfg_mode),
    .cfg_burst (cfg_burst),
    .bus       (bus),
    .busy      (busy),
    .dbg_ptr   (dbg_ptr)
  );

  int             checks = 0;
  int             errors = 0;
  int             cyc    = 0;
  logic [EW-1:0]  exp_q[$];
  logic           cnt_clr = 1'b0;
  int             cnt [NUM_CH];
  logic           gap_en = 1'b0;
  int             prev_t = -1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pat(input int ch, input int idx);
    logic [31:0] w;
    w = {ch[7:0], idx[7:0], 16'hC35A};
    return {16{w}};
  endfunction

  // Source model: each channel presents beat number cnt[c] and advances on acceptance.
  always @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (cnt_clr) cnt[c] <= 0;
      else if (bus.src_val[c] && bus.src_rdy[c]) cnt[c] <= cnt[c] + 1;
    end
  end

  always_comb begin
    bus.src_data = '0;
    for (int c = 0; c < NUM_CH; c++) bus.src_data[c*DW +: DW] = pat(c, cnt[c]);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic clr_cnt();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int ch, input int idx, input bit last);
    exp_q.push_back({CW'(ch), 8'(idx), last});
  endtask

  task automatic finish_test(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      tick();
      t++;
    end
    bus.src_val = '0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) tick();
  endtask

  task automatic chk_zero_outputs(input string pfx);
    chk({pfx, "_dst_val"},  64'(bus.dst_val),  64'd0);
    chk({pfx, "_dst_ch"},   64'(bus.dst_ch),   64'd0);
    chk({pfx, "_dst_last"}, 64'(bus.dst_last), 64'd0);
    chk({pfx, "_dst_data"}, 64'(|bus.dst_data), 64'd0);
    chk({pfx, "_src_rdy"},  64'(bus.src_rdy),  64'd0);
    chk({pfx, "_busy"},     64'(busy),         64'd0);
    chk({pfx, "_dbg_ptr"},  64'(dbg_ptr),      64'd0);
  endtask

  // scoreboard monitor: one pop per transferring output beat
  initial begin
    logic [EW-1:0] e;
    logic [CW-1:0] ech;
    int            eidx;
    logic          elast;
    logic [DW-1:0] pv;
    forever begin
      @(negedge clk);
      if (!rst && bus.dst_val && bus.dst_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got ch %0d data %0h, required no beat", bus.dst_ch, bus.dst_data[31:0]);
        end else begin
          e     = exp_q.pop_front();
          ech   = e[EW-1:9];
          eidx  = int'(e[8:1]);
          elast = e[0];
          pv    = pat(int'(ech), eidx);
          if (bus.dst_ch !== ech || bus.dst_last !== elast || bus.dst_data !== pv) begin
            errors++;
            $display("FAIL beat: got ch %0d last %0d data %0h, expected ch %0d last %0d data %0h",
                     bus.dst_ch, bus.dst_last, bus.dst_data[31:0], ech, elast, pv[31:0]);
          end
        end
        if (gap_en) begin
          if (prev_t >= 0) begin
            checks++;
            if (cyc - prev_t != 2) begin
              errors++;
              $display("FAIL beat_gap: got %0d cycles expected 2", cyc - prev_t);
            end
          end
          prev_t = cyc;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            t;
    logic [DW-1:0] pv;
    rst          = 1'b1;
    cfg_mode     = 1'b0;
    cfg_burst    = 4'd1;
    bus.src_val  = '0;
    bus.dst_rdy  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst = 1'b0;
    clr_cnt();

    // 1: RR, burst 1, all channels valid: 0..47 then 0 again, one beat every 2 cycles
    cfg_mode  = 1'b0;
    cfg_burst = 4'd1;
    for (int i = 0; i < 49; i++) push(i % 48, i / 48, 1'b1);
    gap_en      = 1'b1;
    prev_t      = -1;
    bus.src_val = '1;
    finish_test("t1");
    gap_en = 1'b0;

    // 2: fixed mode, burst 4, ch3 and ch10: ch3 granted twice, ch10 never
    do_reset();
    clr_cnt();
    cfg_mode  = 1'b1;
    cfg_burst = 4'd4;
    for (int i = 0; i < 8; i++) push(3, i, (i % 4) == 3);
    bus.src_val[3]  = 1'b1;
    bus.src_val[10] = 1'b1;
    finish_test("t2");

    // 3: RR, burst 8, ch2, sink stalls 3 cycles while holding beat 1
    do_reset();
    clr_cnt();
    cfg_mode  = 1'b0;
    cfg_burst = 4'd8;
    for (int i = 0; i < 8; i++) push(2, i, i == 7);
    bus.src_val[2] = 1'b1;
    pv = pat(2, 1);
    t  = 0;
    while (!(bus.dst_val && bus.dst_data == pv) && t < 20) begin
      tick();
      t++;
    end
    chk("t3_reach_beat1", 64'(t < 20), 64'd1);
    bus.dst_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_hold_data",    bus.dst_data[63:0], pv[63:0]);
      chk("t3_hold_val",     64'(bus.dst_val),   64'd1);
      chk("t3_hold_src_rdy", 64'(bus.src_rdy),   64'd0);
      @(posedge clk);
      #1;
    end
    bus.dst_rdy = 1'b1;
    finish_test("t3");

    // 4: RR, burst 4, ch5 drops valid after 2 beats
    do_reset();
    clr_cnt();
    cfg_burst = 4'd4;
    push(5, 0, 1'b0);
    push(5, 1, 1'b0);
    bus.src_val[5] = 1'b1;
    repeat (3) tick();
    bus.src_val[5] = 1'b0;
    #1;
    chk("t4_busy_while_full", 64'(busy), 64'd1);
    tick();
    chk("t4_dbg_ptr",  64'(dbg_ptr),     64'd6);
    chk("t4_busy",     64'(busy),        64'd0);
    chk("t4_src_rdy",  64'(bus.src_rdy), 64'd0);
    finish_test("t4");

    // 5: pointer wrap 46 -> 47 -> 0 -> 1
    do_reset();
    clr_cnt();
    cfg_burst = 4'd1;
    push(46, 0, 1'b1);
    push(47, 0, 1'b1);
    push(0, 0, 1'b1);
    bus.src_val[46] = 1'b1;
    repeat (2) tick();
    chk("t5_ptr_47", 64'(dbg_ptr), 64'd47);
    bus.src_val     = '0;
    bus.src_val[47] = 1'b1;
    bus.src_val[0]  = 1'b1;
    repeat (2) tick();
    chk("t5_ptr_0", 64'(dbg_ptr), 64'd0);
    repeat (2) tick();
    chk("t5_ptr_1", 64'(dbg_ptr), 64'd1);
    bus.src_val = '0;
    finish_test("t5");

    // 6: reset mid-burst with a stalled beat in the output register
    clr_cnt();
    cfg_burst = 4'd8;
    push(9, 0, 1'b0);
    bus.src_val[9] = 1'b1;
    repeat (3) tick();
    chk("t6_val_before_rst", 64'(bus.dst_val), 64'd1);
    bus.dst_rdy = 1'b0;
    rst         = 1'b1;
    tick();
    rst         = 1'b0;
    bus.dst_rdy = 1'b1;
    chk_zero_outputs("t6_after_rst");
    cfg_burst = 4'd1;
    push(0, 0, 1'b1);
    push(9, 2, 1'b1);
    bus.src_val[0] = 1'b1;
    bus.src_val[9] = 1'b1;
    finish_test("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
